clk_div_ctrl: RTL
=================

Name: clk_div_ctrl

Overview:
Run-time controller for the project's divided-clock generators. It owns a programmable divide-by-N counter and produces a registered divided clock plus a period-start tick. A requester changes the divisor through a valid/ready handshake. Divisor changes and stops occur only at period boundaries, so the output never produces a runt pulse.

Parameters:
W, 8, width of the divisor and counter
DEF_DIV, 4, divisor loaded at reset (must be >= 2)

Ports:
clk_in  input  1  system clock
rst  input  1  synchronous active-high reset
en  input  1  run request; level-sensitive
cfg_valid  input  1  requester presents a new divisor
cfg_div  input  W  requested divisor N
cfg_ready  output  1  controller can accept a divisor this cycle
err  output  1  one-cycle pulse when an illegal divisor (N<2) is accepted
busy  output  1  divider running (state != OFF)
clk_out  output  1  divided clock, registered
tick  output  1  one-cycle pulse on the first cycle of every output period

Behaviour:
- Clocking and reset: single clock, clk_in. rst is synchronous and active-high.
- Reset values: state=OFF, div_reg=DEF_DIV, cnt=0, pend_div=0, clk_out=0, tick=0, err=0, busy=0, cfg_ready=1.
- Reset mid-operation: behaves identically to the reset above. Any pending divisor is discarded.
- Counter: cnt counts 0..div_reg-1, then wraps to 0.
- High time: H = div_reg - (div_reg>>1).
- Output alignment: clk_out and tick are flops loaded from next-state values. In every cycle with state RUN or PEND, clk_out==(cnt<H) and tick==(cnt==0). In OFF, both are 0.
- Example patterns: N=2 gives 10, N=3 gives 110, N=4 gives 1100.
- State machine (OFF, RUN, PEND):
  - OFF -> RUN when en=1. The first RUN cycle has cnt=0, clk_out=1, tick=1.
  - RUN -> PEND when a legal cfg is accepted while cnt != div_reg-1. pend_div<=cfg_div.
  - PEND -> RUN at the wrap (cnt==div_reg-1 and en=1). div_reg<=pend_div and the next cycle has cnt=0.
  - RUN/PEND -> OFF at the wrap when en=0. A pending divisor is applied to div_reg at that wrap. cnt goes to 0 and clk_out to 0.
  - If en falls and rises again before the wrap, the stop is cancelled and the current period is not disturbed.
- Handshake:
  - Transfer occurs when cfg_valid & cfg_ready.
  - cfg_ready=1 in OFF and RUN, 0 in PEND.
  - Accept in OFF: div_reg<=cfg_div next cycle. If en=1 in the same cycle, RUN starts with the new divisor.
  - Accept in RUN at cnt==div_reg-1: the new divisor takes effect at this wrap, state stays RUN, and no PEND cycle occurs.
  - Illegal divisor (cfg_div<2): the transfer still completes and err=1 for exactly the next cycle. div_reg, pend_div and state are unchanged.
- busy=1 in RUN and PEND, 0 in OFF. It drops the cycle after the final period ends.
- Width rules: cnt and div_reg are W bits. The maximum divisor is 2^W-1. No arithmetic exceeds W bits.

Test Plan:
1. Reset for 15 ns (10 ns clock), then en=1 with DEF_DIV=4 -> clk_out 1100 repeating, tick every 4th cycle with the first on the first RUN cycle, busy=1.
2. Running N=4; cfg_div=3 accepted at cnt=1 -> cfg_ready=0 for cycles cnt=2..3, the 1100 period completes, then 110 repeats and cfg_ready=1 again.
3. Running N=4; cfg_div=6 accepted at cnt=3 -> the next cycle starts 111000 directly, and cfg_ready never drops.
4. cfg_div=1 or 0 while running N=4 -> err=1 for exactly one cycle, output pattern unchanged, state stays RUN.
5. Running N=6; en=0 at cnt=1 -> output continues 1,1,0,0,0 through cnt=5, then clk_out=0, tick=0 and busy=0 from the next cycle. en re-pulsed at cnt=3 in a repeat run -> no stop.
6. rst asserted while in PEND -> next cycle shows all reset values, the pending divisor is lost, and a later en=1 runs 1100 (N=4).

Source files
------------

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Run-time controller for a programmable divide-by-N clock generator.
// The counter cnt runs 0..div_reg-1. clk_out is high for the first
// H = div_reg - (div_reg>>1) counts of each period, and tick marks count 0.
// Divisor changes and stops are applied only at the period wrap, so the
// output never produces a runt pulse.
//
// Ports:
//   clk_in     system clock
//   rst        synchronous active-high reset
//   en         run request (level); sampled at period wraps while running
//   cfg_valid  requester presents a new divisor on cfg_div
//   cfg_div    requested divisor N (legal when N >= 2)
//   cfg_ready  divisor can be accepted this cycle (low while one is pending)
//   err        one-cycle pulse after an illegal divisor was accepted
//   busy       divider running (RUN or PEND)
//   clk_out    divided clock, registered
//   tick       one-cycle pulse on the first cycle of every output period
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
   parameter int          W       = 8,
   parameter int unsigned DEF_DIV = 4
) (
   input  logic         clk_in,
   input  logic         rst,
   input  logic         en,
   input  logic         cfg_valid,
   input  logic [W-1:0] cfg_div,
   output logic         cfg_ready,
   output logic         err,
   output logic         busy,
   output logic         clk_out,
   output logic         tick
);

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t       state;
   state_t       state_nx;
   logic [W-1:0] div_reg;
   logic [W-1:0] div_nx;
   logic [W-1:0] cnt;
   logic [W-1:0] cnt_nx;
   logic [W-1:0] pend_div;
   logic [W-1:0] pend_nx;
   logic         xfer;
   logic         legal;
   logic         take;
   logic         wrap;
   logic         run_nx;
   logic         clk_nx;
   logic         tick_nx;
   logic         busy_nx;
   logic         ready_nx;
   logic         err_nx;

   // High portion of a period of length n (ceil(n/2)), kept within W bits.
   function automatic logic [W-1:0] high_time(input logic [W-1:0] n);
      return n - (n >> 1);
   endfunction

   // State register and all registered outputs, loaded from next-state values.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state     <= OFF;
         div_reg   <= W'(DEF_DIV);
         cnt       <= '0;
         pend_div  <= '0;
         clk_out   <= 1'b0;
         tick      <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         cfg_ready <= 1'b1;
      end else begin
         state     <= state_nx;
         div_reg   <= div_nx;
         cnt       <= cnt_nx;
         pend_div  <= pend_nx;
         clk_out   <= clk_nx;
         tick      <= tick_nx;
         err       <= err_nx;
         busy      <= busy_nx;
         cfg_ready <= ready_nx;
      end
   end

   // Next-state logic: counter, divisor update and state transitions.
   always_comb begin
      state_nx = state;
      div_nx   = div_reg;
      cnt_nx   = cnt;
      pend_nx  = pend_div;
      xfer     = cfg_valid & cfg_ready;
      legal    = (cfg_div >= W'(2));
      take     = xfer & legal;
      wrap     = (cnt == (div_reg - W'(1)));
      case (state)
         OFF: begin
            cnt_nx = '0;
            // A divisor accepted here is used by a RUN starting next cycle.
            if (take) begin
               div_nx = cfg_div;
            end else begin
               div_nx = div_reg;
            end
            if (en) begin
               state_nx = RUN;
            end else begin
               state_nx = OFF;
            end
         end
         RUN: begin
            if (wrap) begin
               cnt_nx = '0;
               // Accepting on the last count applies immediately at this wrap.
               if (take) begin
                  div_nx = cfg_div;
               end else begin
                  div_nx = div_reg;
               end
               if (en) begin
                  state_nx = RUN;
               end else begin
                  state_nx = OFF;
               end
            end else begin
               cnt_nx = cnt + W'(1);
               if (take) begin
                  state_nx = PEND;
                  pend_nx  = cfg_div;
               end else begin
                  state_nx = RUN;
               end
            end
         end
         PEND: begin
            if (wrap) begin
               cnt_nx = '0;
               div_nx = pend_div;
               if (en) begin
                  state_nx = RUN;
               end else begin
                  state_nx = OFF;
               end
            end else begin
               cnt_nx   = cnt + W'(1);
               state_nx = PEND;
            end
         end
         default: begin
            state_nx = OFF;
            cnt_nx   = '0;
         end
      endcase
   end

   // Output decode from the next state so the flops line up with cnt.
   always_comb begin
      run_nx   = (state_nx != OFF);
      clk_nx   = run_nx && (cnt_nx < high_time(div_nx));
      tick_nx  = run_nx && (cnt_nx == '0);
      busy_nx  = run_nx;
      ready_nx = (state_nx != PEND);
      err_nx   = xfer & ~legal;
   end

endmodule
